// File: rtl/mem_access_if.sv
// Data-memory port of the memory-access stage: a registered request and a
// one-cycle ack pulse that carries the read data.
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    dmem_req;
    logic                    dmem_we;
    logic [ADDR_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_be;
    logic                    dmem_ack;
    logic [DATA_WIDTH-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// minuteCore memory-access stage: runs loads/stores on the data-memory port,
// raises alignment/funct3 exceptions, and passes other instructions through.
module mem_access #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int EX_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           PC_in,
    input  logic [31:0]           instr_in,
    input  logic [4:0]            opcode_in,
    input  logic [2:0]            funct_in,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [4:0]            rd_addr_in,
    input  logic [EX_WIDTH-1:0]   exception_in,
    input  logic                  exception_in_valid,
    input  logic                  pipeline_in_valid,
    input  logic                  nop_instr_in,
    input  logic                  flush_in,
    output logic                  stall_out,
    mem_access_if.master          dmem,
    output logic [31:0]           PC_out,
    output logic [31:0]           instr_out,
    output logic [4:0]            opcode_out,
    output logic [4:0]            rd_addr_out,
    output logic                  nop_instr_out,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_en,
    output logic [EX_WIDTH-1:0]   exception_out,
    output logic                  exception_out_valid,
    output logic                  pipeline_out_valid
);
    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;
    localparam logic [4:0] OPC_OP    = 5'b01100;
    localparam logic [4:0] OPC_OPIMM = 5'b00100;
    localparam logic [4:0] OPC_LUI   = 5'b01101;
    localparam logic [4:0] OPC_AUIPC = 5'b00101;
    localparam logic [4:0] OPC_JAL   = 5'b11011;
    localparam logic [4:0] OPC_JALR  = 5'b11001;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nx;
    logic          is_load, is_store, funct_legal, misaligned, qualified;
    logic          mem_go, local_exc, writes_rd;
    logic [EX_WIDTH-1:0] local_code;
    logic [2:0]    funct_q;
    logic [1:0]    addr_lo_q;
    logic          discard_q;
    logic [31:0]   lane, load_val;
    logic [3:0]    be_nx;
    logic [31:0]   wdata_nx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        is_load     = (opcode_in == OPC_LOAD);
        is_store    = (opcode_in == OPC_STORE);
        funct_legal = 1'b0;
        if (is_load)
            funct_legal = funct_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store)
            funct_legal = funct_in inside {3'b000, 3'b001, 3'b010};
        misaligned  = ((funct_in[1:0] == 2'b01) && addr_in[0]) ||
                      ((funct_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
        qualified   = (state == IDLE) && pipeline_in_valid && !exception_in_valid &&
                      !nop_instr_in && (is_load || is_store) && !flush_in;
        mem_go      = qualified && funct_legal && !misaligned;
        local_exc   = qualified && !(funct_legal && !misaligned);
        local_code  = !funct_legal ? EX_WIDTH'(2) : (is_load ? EX_WIDTH'(4) : EX_WIDTH'(6));
        writes_rd   = opcode_in inside {OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
        stall_out   = !reset && (mem_go || ((state == WAIT) && !dmem.dmem_ack));

        case (funct_in[1:0])
            2'b00:   begin be_nx = 4'b0001 << addr_in[1:0]; wdata_nx = {4{result_in[7:0]}};  end
            2'b01:   begin be_nx = addr_in[1] ? 4'b1100 : 4'b0011; wdata_nx = {2{result_in[15:0]}}; end
            default: begin be_nx = 4'b1111; wdata_nx = result_in; end
        endcase

        lane = dmem.dmem_rdata >> {addr_lo_q, 3'b000};
        case (funct_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'b0, lane[7:0]};
            3'b101:  load_val = {16'b0, lane[15:0]};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mem_go) state_nx = WAIT;
            WAIT:    if (dmem.dmem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: reset is synchronous here, so it is sampled inside the clocked branch, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem.dmem_req       <= 1'b0;
            dmem.dmem_we        <= 1'b0;
            dmem.dmem_addr      <= '0;
            dmem.dmem_wdata     <= '0;
            dmem.dmem_be        <= '0;
            funct_q             <= '0;
            addr_lo_q           <= '0;
            discard_q           <= 1'b0;
            PC_out              <= '0;
            instr_out           <= '0;
            opcode_out          <= '0;
            rd_addr_out         <= '0;
            nop_instr_out       <= 1'b0;
            wb_data             <= '0;
            wb_en               <= 1'b0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
            pipeline_out_valid  <= 1'b0;
        end else if (state == IDLE) begin
            if (mem_go) begin
                dmem.dmem_req       <= 1'b1;
                dmem.dmem_we        <= is_store;
                dmem.dmem_addr      <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
                dmem.dmem_wdata     <= wdata_nx;
                dmem.dmem_be        <= be_nx;
                funct_q             <= funct_in;
                addr_lo_q           <= addr_in[1:0];
                discard_q           <= 1'b0;
                PC_out              <= PC_in;
                instr_out           <= instr_in;
                opcode_out          <= opcode_in;
                rd_addr_out         <= rd_addr_in;
                nop_instr_out       <= 1'b0;
                exception_out       <= '0;
                exception_out_valid <= 1'b0;
                pipeline_out_valid  <= 1'b0;
            end else if (pipeline_in_valid && !flush_in) begin
                PC_out              <= PC_in;
                instr_out           <= instr_in;
                opcode_out          <= opcode_in;
                rd_addr_out         <= rd_addr_in;
                nop_instr_out       <= nop_instr_in;
                wb_data             <= result_in;
                wb_en               <= !local_exc && !exception_in_valid && !nop_instr_in &&
                                       writes_rd && (rd_addr_in != 5'd0);
                exception_out       <= local_exc ? local_code : exception_in;
                exception_out_valid <= local_exc || exception_in_valid;
                pipeline_out_valid  <= 1'b1;
            end else begin
                pipeline_out_valid  <= 1'b0;
            end
        end else begin
            if (flush_in) discard_q <= 1'b1;
            pipeline_out_valid <= 1'b0;
            if (dmem.dmem_ack) begin
                dmem.dmem_req <= 1'b0;
                // A flushed transaction still completes on the bus; only its result is dropped.
                if (!(discard_q || flush_in)) begin
                    pipeline_out_valid <= 1'b1;
                    wb_data            <= dmem.dmem_we ? '0 : load_val;
                    wb_en              <= !dmem.dmem_we && (rd_addr_out != 5'd0);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: the bench plays data memory and checks
// every cycle of each scenario against hand-computed values.
module tb_mem_access;
    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;
    localparam logic [4:0] OPC_OP    = 5'b01100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_in, instr_in, result_in, addr_in;
    logic [4:0]  opcode_in, rd_addr_in;
    logic [2:0]  funct_in;
    logic [3:0]  exception_in;
    logic        exception_in_valid, pipeline_in_valid, nop_instr_in, flush_in;
    logic        stall_out;
    logic [31:0] PC_out, instr_out, wb_data;
    logic [4:0]  opcode_out, rd_addr_out;
    logic        nop_instr_out, wb_en, exception_out_valid, pipeline_out_valid;
    logic [3:0]  exception_out;

    int total = 0;
    int bad   = 0;
    int stall_cnt;

    mem_access_if bus ();

    mem_access dut (
        .clk(clk), .reset(reset),
        .PC_in(PC_in), .instr_in(instr_in), .opcode_in(opcode_in), .funct_in(funct_in),
        .result_in(result_in), .addr_in(addr_in), .rd_addr_in(rd_addr_in),
        .exception_in(exception_in), .exception_in_valid(exception_in_valid),
        .pipeline_in_valid(pipeline_in_valid), .nop_instr_in(nop_instr_in),
        .flush_in(flush_in), .stall_out(stall_out), .dmem(bus.master),
        .PC_out(PC_out), .instr_out(instr_out), .opcode_out(opcode_out),
        .rd_addr_out(rd_addr_out), .nop_instr_out(nop_instr_out), .wb_data(wb_data),
        .wb_en(wb_en), .exception_out(exception_out),
        .exception_out_valid(exception_out_valid), .pipeline_out_valid(pipeline_out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] opc, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] res, input logic [4:0] rd,
                         input logic [31:0] pc);
        pipeline_in_valid  = v;
        opcode_in          = opc;
        funct_in           = f;
        addr_in            = addr;
        result_in          = res;
        rd_addr_in         = rd;
        PC_in              = pc;
        instr_in           = ~pc;
        nop_instr_in       = 1'b0;
        exception_in       = 4'd0;
        exception_in_valid = 1'b0;
    endtask

    task automatic idle_in();
        drive(1'b0, OPC_OP, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        flush_in = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        drive(1'b1, OPC_LOAD, 3'b010, 32'h4000, 32'h0, 5'd1, 32'h40);
        tick();
        tick();
        #1;
        check("rst_stall_forced", stall_out, 0);
        check("rst_req", bus.dmem_req, 0);
        check("rst_valid", pipeline_out_valid, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_exc_valid", exception_out_valid, 0);
        reset = 1'b0;
        idle_in();
        tick();

        // LB at 0x1001, ack one cycle after req
        drive(1'b1, OPC_LOAD, 3'b000, 32'h1001, 32'h0, 5'd3, 32'h100);
        stall_cnt = 0;
        #1;
        check("lb_stall_go", stall_out, 1);
        if (stall_out) stall_cnt++;
        tick();
        check("lb_req", bus.dmem_req, 1);
        check("lb_we", bus.dmem_we, 0);
        check("lb_be", bus.dmem_be, 4'b0010);
        check("lb_addr", bus.dmem_addr, 32'h1000);
        check("lb_valid_wait", pipeline_out_valid, 0);
        check("lb_stall_wait", stall_out, 1);
        if (stall_out) stall_cnt++;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h0000_8000;
        #1;
        check("lb_stall_ack", stall_out, 0);
        tick();
        bus.dmem_ack = 1'b0;
        idle_in();
        check("lb_valid", pipeline_out_valid, 1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_en", wb_en, 1);
        check("lb_rd", rd_addr_out, 3);
        check("lb_pc", PC_out, 32'h100);
        check("lb_req_clear", bus.dmem_req, 0);
        check("lb_stall_cycles", stall_cnt, 2);

        // SH at 0x2002, ack after 3 wait cycles
        drive(1'b1, OPC_STORE, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd4, 32'h200);
        stall_cnt = 0;
        #1;
        if (stall_out) stall_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("sh_req", bus.dmem_req, 1);
            check("sh_we", bus.dmem_we, 1);
            check("sh_be", bus.dmem_be, 4'b1100);
            check("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
            check("sh_addr", bus.dmem_addr, 32'h2000);
            if (stall_out) stall_cnt++;
            tick();
        end
        check("sh_req_last", bus.dmem_req, 1);
        bus.dmem_ack = 1'b1;
        #1;
        if (stall_out) stall_cnt++;
        tick();
        bus.dmem_ack = 1'b0;
        idle_in();
        check("sh_stall_cycles", stall_cnt, 4);
        check("sh_valid", pipeline_out_valid, 1);
        check("sh_wb_en", wb_en, 0);
        check("sh_wb_data", wb_data, 0);

        // Misaligned and illegal memory ops
        drive(1'b1, OPC_LOAD, 3'b010, 32'h3001, 32'h0, 5'd2, 32'h300);
        #1;
        check("lw_mis_stall", stall_out, 0);
        tick();
        drive(1'b1, OPC_STORE, 3'b010, 32'h3002, 32'h0, 5'd2, 32'h304);
        check("lw_mis_req", bus.dmem_req, 0);
        check("lw_mis_code", exception_out, 4);
        check("lw_mis_exv", exception_out_valid, 1);
        check("lw_mis_wb_en", wb_en, 0);
        check("lw_mis_valid", pipeline_out_valid, 1);
        tick();
        drive(1'b1, OPC_LOAD, 3'b011, 32'h3000, 32'h0, 5'd2, 32'h308);
        check("sw_mis_req", bus.dmem_req, 0);
        check("sw_mis_code", exception_out, 6);
        check("sw_mis_exv", exception_out_valid, 1);
        tick();
        idle_in();
        check("ld_ill_code", exception_out, 2);
        check("ld_ill_req", bus.dmem_req, 0);

        // Back-to-back ADDs
        drive(1'b1, OPC_OP, 3'b000, 32'h0, 32'h55, 5'd5, 32'h400);
        #1;
        check("add1_stall", stall_out, 0);
        tick();
        drive(1'b1, OPC_OP, 3'b000, 32'h0, 32'h66, 5'd0, 32'h404);
        #1;
        check("add2_stall", stall_out, 0);
        check("add1_valid", pipeline_out_valid, 1);
        check("add1_wb_data", wb_data, 32'h55);
        check("add1_wb_en", wb_en, 1);
        check("add1_exv", exception_out_valid, 0);
        tick();
        idle_in();
        check("add2_valid", pipeline_out_valid, 1);
        check("add2_wb_data", wb_data, 32'h66);
        check("add2_wb_en", wb_en, 0);
        tick();
        check("bubble_valid", pipeline_out_valid, 0);
        check("bubble_hold", wb_data, 32'h66);

        // Reset while in WAIT, ack arrives the cycle after
        drive(1'b1, OPC_LOAD, 3'b010, 32'h4000, 32'h0, 5'd6, 32'h500);
        tick();
        idle_in();
        check("rw_req", bus.dmem_req, 1);
        reset = 1'b1;
        #1;
        check("rw_stall_forced", stall_out, 0);
        tick();
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        check("rw_req_clear", bus.dmem_req, 0);
        check("rw_pc", PC_out, 0);
        check("rw_wb_data", wb_data, 0);
        check("rw_valid", pipeline_out_valid, 0);
        tick();
        bus.dmem_ack = 1'b0;
        check("rw_late_ack_valid", pipeline_out_valid, 0);
        check("rw_late_ack_wb", wb_data, 0);
        check("rw_late_ack_req", bus.dmem_req, 0);

        // Flush in WAIT, then ack; next instruction right after
        drive(1'b1, OPC_LOAD, 3'b010, 32'h5000, 32'h0, 5'd7, 32'h600);
        tick();
        idle_in();
        flush_in = 1'b1;
        #1;
        check("fw_stall", stall_out, 1);
        tick();
        flush_in = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        #1;
        check("fw_stall_ack", stall_out, 0);
        tick();
        bus.dmem_ack = 1'b0;
        drive(1'b1, OPC_OP, 3'b000, 32'h0, 32'h77, 5'd9, 32'h700);
        check("fw_valid", pipeline_out_valid, 0);
        check("fw_req_clear", bus.dmem_req, 0);
        tick();
        idle_in();
        check("fw_next_valid", pipeline_out_valid, 1);
        check("fw_next_wb_data", wb_data, 32'h77);
        check("fw_next_wb_en", wb_en, 1);

        // Flush in IDLE drops a load; stray ack in IDLE ignored
        drive(1'b1, OPC_LOAD, 3'b010, 32'h6000, 32'h0, 5'd8, 32'h800);
        flush_in = 1'b1;
        #1;
        check("fi_stall", stall_out, 0);
        tick();
        flush_in = 1'b0;
        idle_in();
        bus.dmem_ack = 1'b1;
        check("fi_req", bus.dmem_req, 0);
        check("fi_valid", pipeline_out_valid, 0);
        tick();
        bus.dmem_ack = 1'b0;
        check("idle_ack_valid", pipeline_out_valid, 0);
        check("idle_ack_req", bus.dmem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the minuteCore pipeline. It sits between execute and writeback. It consumes execute's registered outputs: result, address, opcode, funct3, rd and exception. For loads and stores it runs a req/ack transaction on the data-memory port and stalls upstream until the transaction completes. It forms byte enables and aligned store data, and sign- or zero-extends load data. All other instructions pass through to writeback in one cycle.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; only 32 is supported
- EX_WIDTH, 4, exception code width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- PC_in, instr_in  in  32 each  passed through unchanged
- opcode_in  in  5  instr[6:2]: LOAD=00000, STORE=01000, OP=01100, OP_IMM=00100, LUI=01101, AUIPC=00101, JAL=11011, JALR=11001
- funct_in  in  3  funct3
- result_in  in  32  ALU result for non-memory ops; store data for STORE
- addr_in  in  32  effective byte address
- rd_addr_in  in  5  destination register
- exception_in  in  EX_WIDTH  upstream exception code
- exception_in_valid, pipeline_in_valid, nop_instr_in  in  1 each  upstream qualifiers
- flush_in  in  1  pipeline flush
- stall_out  out  1  combinational; holds execute's outputs
- dmem_req  out  1  registered request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_wdata  out  32  replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  read data; valid when dmem_ack=1
- PC_out, instr_out  out  32 each  registered copies of PC_in, instr_in
- opcode_out  out  5  registered
- rd_addr_out  out  5  registered
- nop_instr_out  out  1  registered
- wb_data  out  32  registered writeback value
- wb_en  out  1  registered register-write enable
- exception_out  out  EX_WIDTH  registered
- exception_out_valid  out  1  registered
- pipeline_out_valid  out  1  registered

## Operation
- States: IDLE, WAIT.
- mem_go is true when all of these hold: state is IDLE, pipeline_in_valid=1, exception_in_valid=0, nop_instr_in=0, opcode is LOAD or STORE, funct3 is legal, the address is aligned, flush_in=0.
- Legal funct3 for LOAD: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for STORE: 000 SB, 001 SH, 010 SW. Any other funct3 produces exception code 2 (illegal instruction).
- Misalignment is H with addr[0]=1, or W with addr[1:0]≠0. A misaligned LOAD produces exception code 4; a misaligned STORE produces code 6.
- An exception raised here is output in one cycle with exception_out_valid=1 and wb_en=0. No memory request is made.
- Byte enables:
  - B: 1<<addr[1:0]
  - H: addr[1] ? 1100 : 0011
  - W: 1111
- Store data:
  - B: {4{result_in[7:0]}}
  - H: {2{result_in[15:0]}}
  - W: result_in
- Load extraction: lane = dmem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15 of the lane.
  - LBU/LHU zero-extend.
  - LW uses the full word.
- IDLE with mem_go: latch the request fields, PC, instr, rd and opcode; set dmem_req=1 next cycle; go to WAIT.
- WAIT: hold dmem_req and all dmem_* fields stable until dmem_ack=1. On ack:
  - register the outputs with pipeline_out_valid=1;
  - LOAD: wb_data is the extended lane, wb_en = (rd≠0);
  - STORE: wb_data = 0, wb_en = 0;
  - clear dmem_req; go to IDLE.
- IDLE, valid input, not mem_go and not flush:
  - pass through in one cycle;
  - wb_data = result_in;
  - wb_en = (rd≠0) when opcode ∈ {OP, OP_IMM, LUI, AUIPC, JAL, JALR}, no exception and not NOP;
  - upstream exception_in and exception_in_valid are copied.
- IDLE, pipeline_in_valid=0: pipeline_out_valid=0 next cycle; the other outputs hold.
- stall_out = mem_go OR (state==WAIT AND dmem_ack=0). It is forced to 0 while reset=1.

## Timing
- Reset values:
  - state IDLE;
  - dmem_req, dmem_we, pipeline_out_valid, wb_en, exception_out_valid, nop_instr_out = 0;
  - all data outputs = 0.
- Non-memory latency: output valid on the cycle after acceptance.
- Memory latency: accepted at edge N; dmem_req visible in N+1. With ack in cycle N+k (k≥1), the output is valid in N+k+1.
- Minimum occupancy for a memory op is 2 cycles; throughput is one memory op per 2 cycles.
- dmem_ack while in IDLE is ignored.
- flush_in in IDLE: the input is dropped, no request is issued, pipeline_out_valid=0 next cycle.
- flush_in in WAIT: the transaction cannot be aborted and completes on the bus, so a store still writes. The result is discarded: on ack pipeline_out_valid=0. stall_out continues to follow the WAIT rule.
- reset in WAIT: state IDLE and dmem_req=0 at the next edge. A late ack is ignored.
- Simultaneous ack and flush in WAIT: go to IDLE, output not valid.

## Test plan
- LB, addr=0x1001, rdata=0x0000_8000, ack one cycle after req -> dmem_be=0010, dmem_addr=0x1000; wb_data=0xFFFF_FF80, wb_en=1; output valid 2 cycles after acceptance; stall_out high for 2 cycles.
- SH, addr=0x2002, result_in=0x1234_ABCD, ack after 3 wait cycles -> dmem_we=1, be=1100, wdata=0xABCD_ABCD; fields stable through WAIT; stall_out high for 4 cycles; wb_en=0.
- LW at addr=0x3001 -> no dmem_req; exception_out=4, exception_out_valid=1, wb_en=0 next cycle. SW at 0x3002 -> code 6.
- ADD, result_in=0x55, rd=5, followed by ADD with rd=0 -> consecutive valid outputs; wb_en 1 then 0; stall_out never asserted.
- reset asserted in WAIT with ack arriving the cycle after -> dmem_req=0 and all outputs at reset values; no valid output.
- flush_in in WAIT, then ack -> pipeline_out_valid stays 0; next instruction accepted in the cycle after ack.
